// File: rtl/tdc_meas_sequencer_if.sv
// Host/core signal bundle for the TDC measurement sequencer.
// The sequencer takes the slave view; the host and TDC core side take the master view.
interface tdc_meas_sequencer_if #(
   parameter int unsigned HW_W  = 7,
   parameter int unsigned CNT_W = 8
);
   logic                    start;
   logic [CNT_W-1:0]        n_samples;
   logic                    src_sel;
   logic                    bypass_sel;
   logic [HW_W-1:0]         tdc_hw;
   logic                    tdc_val;
   logic                    pg_src;
   logic                    pg_bypass;
   logic                    pg_in;
   logic                    val_in;
   logic                    busy;
   logic                    done;
   logic [HW_W+CNT_W-1:0]   hw_sum;
   logic [HW_W-1:0]         hw_min;
   logic [HW_W-1:0]         hw_max;
   logic [CNT_W-1:0]        n_valid;
   logic                    timeout_err;

   modport master (
      output start, n_samples, src_sel, bypass_sel, tdc_hw, tdc_val,
      input  pg_src, pg_bypass, pg_in, val_in, busy, done,
      input  hw_sum, hw_min, hw_max, n_valid, timeout_err
   );

   modport slave (
      input  start, n_samples, src_sel, bypass_sel, tdc_hw, tdc_val,
      output pg_src, pg_bypass, pg_in, val_in, busy, done,
      output hw_sum, hw_min, hw_max, n_valid, timeout_err
   );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// Runs N launch/valid transactions on the mux-delay TDC core and folds the
// returned Hamming weights into sum/min/max/valid-count for the host.
module tdc_meas_sequencer #(
   parameter int unsigned HW_W       = 7,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   tdc_meas_sequencer_if.slave bus
);
   localparam int unsigned SumW = HW_W + CNT_W;
   localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);
   localparam logic [TmoW-1:0] TmoLast    = TmoW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StLaunch,
      StWait,
      StFin
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  n_lat_q;
   logic [CNT_W-1:0]  issued_q;
   logic [SetW-1:0]   settle_cnt_q;
   logic [TmoW-1:0]   tmo_cnt_q;
   logic              pg_src_q;
   logic              pg_bypass_q;
   logic              pg_in_q;
   logic              val_in_q;
   logic              busy_q;
   logic              done_q;
   logic [SumW-1:0]   hw_sum_q;
   logic [HW_W-1:0]   hw_min_q;
   logic [HW_W-1:0]   hw_max_q;
   logic [CNT_W-1:0]  n_valid_q;
   logic              timeout_err_q;

   logic [CNT_W-1:0]  issued_inc;
   logic              sample_end;
   logic              last_sample;
   logic [SumW-1:0]   hw_ext;

   always_comb begin
      issued_inc  = issued_q + CNT_W'(1);
      last_sample = (issued_inc == n_lat_q);
      // A sample ends on accept or when its wait window expires.
      sample_end  = bus.tdc_val || (tmo_cnt_q == TmoLast);
      hw_ext      = SumW'(bus.tdc_hw);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         n_lat_q       <= '0;
         issued_q      <= '0;
         settle_cnt_q  <= '0;
         tmo_cnt_q     <= '0;
         pg_src_q      <= 1'b0;
         pg_bypass_q   <= 1'b0;
         pg_in_q       <= 1'b0;
         val_in_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         hw_sum_q      <= '0;
         hw_min_q      <= '1;
         hw_max_q      <= '0;
         n_valid_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         val_in_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  n_lat_q       <= bus.n_samples;
                  pg_src_q      <= bus.src_sel;
                  pg_bypass_q   <= bus.bypass_sel;
                  issued_q      <= '0;
                  settle_cnt_q  <= '0;
                  hw_sum_q      <= '0;
                  hw_min_q      <= '1;
                  hw_max_q      <= '0;
                  n_valid_q     <= '0;
                  timeout_err_q <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= (bus.n_samples == '0) ? StFin : StSettle;
               end
            end
            StSettle: begin
               if (settle_cnt_q == SettleLast) begin
                  state_q <= StLaunch;
               end else begin
                  settle_cnt_q <= settle_cnt_q + SetW'(1);
               end
            end
            StLaunch: begin
               // Edge polarity alternates per sample and carries across runs.
               pg_in_q   <= ~pg_in_q;
               val_in_q  <= 1'b1;
               tmo_cnt_q <= '0;
               state_q   <= StWait;
            end
            StWait: begin
               if (bus.tdc_val) begin
                  hw_sum_q  <= hw_sum_q + hw_ext;
                  n_valid_q <= n_valid_q + CNT_W'(1);
                  if (bus.tdc_hw < hw_min_q) hw_min_q <= bus.tdc_hw;
                  if (bus.tdc_hw > hw_max_q) hw_max_q <= bus.tdc_hw;
               end else if (tmo_cnt_q == TmoLast) begin
                  timeout_err_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
               end
               if (sample_end) begin
                  issued_q <= issued_inc;
                  state_q  <= last_sample ? StFin : StLaunch;
               end
            end
            StFin: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.pg_src      = pg_src_q;
   assign bus.pg_bypass   = pg_bypass_q;
   assign bus.pg_in       = pg_in_q;
   assign bus.val_in      = val_in_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hw_sum      = hw_sum_q;
   assign bus.hw_min      = hw_min_q;
   assign bus.hw_max      = hw_max_q;
   assign bus.n_valid     = n_valid_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed and randomized runs of tdc_meas_sequencer against a per-run
// reference computed from the sample plan (delays, weights, drops).
module tb_tdc_meas_sequencer;
   localparam int unsigned HW_W       = 7;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned SETTLE_CYC = 4;
   localparam int unsigned TIMEOUT    = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tdc_meas_sequencer_if #(.HW_W(HW_W), .CNT_W(CNT_W)) bus ();

   tdc_meas_sequencer #(
      .HW_W       (HW_W),
      .CNT_W      (CNT_W),
      .SETTLE_CYC (SETTLE_CYC),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int vin_cnt  = 0;
   int busy_cnt = 0;
   int plan_d[$];
   int plan_hw[$];
   int rsp_d[$];
   int rsp_hw[$];
   bit pg_exp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (bus.val_in) vin_cnt  <= vin_cnt + 1;
      if (bus.busy)   busy_cnt <= busy_cnt + 1;
   end

   // Core model: answers the k-th val_in after plan delay d (-1 = never); noise when idle.
   initial begin : core_model
      int cnt;
      int hold;
      int d;
      cnt  = 0;
      hold = 0;
      bus.tdc_val = 1'b0;
      bus.tdc_hw  = '0;
      forever begin
         @(negedge clk);
         bus.tdc_val = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else if (bus.val_in) begin
            d    = (rsp_d.size() > 0) ? rsp_d.pop_front() : -1;
            hold = (rsp_hw.size() > 0) ? rsp_hw.pop_front() : 0;
            if (d == 0) begin
               bus.tdc_val = 1'b1;
               bus.tdc_hw  = HW_W'(hold);
            end else if (d > 0) begin
               cnt = d;
            end
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               bus.tdc_val = 1'b1;
               bus.tdc_hw  = HW_W'(hold);
            end
         end else if (!bus.busy) begin
            bus.tdc_val = 1'($urandom_range(0, 1));
            bus.tdc_hw  = HW_W'($urandom_range(0, 127));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic plan_add(input int d, input int hw);
      plan_d.push_back(d);
      plan_hw.push_back(hw);
   endtask

   task automatic run_plan(input int n, input bit src, input bit byp, input bit mid);
      int exp_sum, exp_min, exp_max, exp_nv, exp_cyc, k0, d0, v0, b0, waited;
      bit exp_to;
      exp_sum = 0; exp_min = 127; exp_max = 0; exp_nv = 0; exp_to = 1'b0;
      exp_cyc = (n == 0) ? 2 : 2 + SETTLE_CYC;
      for (int i = 0; i < n; i++) begin
         if (plan_d[i] < 0) begin
            exp_to  = 1'b1;
            exp_cyc += 1 + TIMEOUT;
         end else begin
            exp_sum += plan_hw[i];
            exp_nv++;
            if (plan_hw[i] < exp_min) exp_min = plan_hw[i];
            if (plan_hw[i] > exp_max) exp_max = plan_hw[i];
            exp_cyc += 2 + plan_d[i];
         end
      end
      rsp_d  = plan_d;
      rsp_hw = plan_hw;
      d0 = done_cnt; v0 = vin_cnt; b0 = busy_cnt;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.n_samples  = n[CNT_W-1:0];
      bus.src_sel    = src;
      bus.bypass_sel = byp;
      k0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (mid) begin
         repeat (3) @(negedge clk);
         bus.start      = 1'b1;
         bus.src_sel    = ~src;
         bus.bypass_sel = ~byp;
         @(negedge clk);
         bus.start = 1'b0;
         chk("mid_pg_src", 32'(bus.pg_src), 32'(src));
         chk("mid_pg_bypass", 32'(bus.pg_bypass), 32'(byp));
      end
      waited = 0;
      while (done_cnt == d0 && waited < exp_cyc + 40) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      pg_exp ^= n[0];
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("done_latency", 32'(done_cyc - k0), 32'(exp_cyc));
      chk("busy_cycles", 32'(busy_cnt - b0), 32'(exp_cyc - 1));
      chk("val_in_pulses", 32'(vin_cnt - v0), 32'(n));
      chk("hw_sum", 32'(bus.hw_sum), 32'(exp_sum));
      chk("hw_min", 32'(bus.hw_min), 32'(exp_min));
      chk("hw_max", 32'(bus.hw_max), 32'(exp_max));
      chk("n_valid", 32'(bus.n_valid), 32'(exp_nv));
      chk("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
      chk("busy_end", 32'(bus.busy), 32'd0);
      chk("pg_in", 32'(bus.pg_in), 32'(pg_exp));
      chk("pg_src", 32'(bus.pg_src), 32'(src));
      chk("pg_bypass", 32'(bus.pg_bypass), 32'(byp));
      plan_d.delete();
      plan_hw.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_hw_sum"}, 32'(bus.hw_sum), 32'd0);
      chk({tag, "_hw_min"}, 32'(bus.hw_min), 32'h7f);
      chk({tag, "_hw_max"}, 32'(bus.hw_max), 32'd0);
      chk({tag, "_n_valid"}, 32'(bus.n_valid), 32'd0);
      chk({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
      chk({tag, "_val_in"}, 32'(bus.val_in), 32'd0);
      chk({tag, "_pg_in"}, 32'(bus.pg_in), 32'd0);
      chk({tag, "_pg_src"}, 32'(bus.pg_src), 32'd0);
      chk({tag, "_pg_bypass"}, 32'(bus.pg_bypass), 32'd0);
   endtask

   initial begin : main
      int n, d0, v0, waited;
      bus.start      = 1'b0;
      bus.n_samples  = '0;
      bus.src_sel    = 1'b0;
      bus.bypass_sel = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Four samples answered one cycle after val_in.
      plan_add(1, 10); plan_add(1, 20); plan_add(1, 5); plan_add(1, 30);
      run_plan(4, 1'b1, 1'b0, 1'b0);

      // Core silent: every sample times out.
      plan_add(-1, 0); plan_add(-1, 0); plan_add(-1, 0);
      run_plan(3, 1'b0, 1'b1, 1'b0);

      run_plan(0, 1'b1, 1'b1, 1'b0);

      // Restart and config change while busy must be ignored.
      for (int i = 0; i < 4; i++) plan_add($urandom_range(0, 3), $urandom_range(0, 127));
      run_plan(4, 1'b0, 1'b1, 1'b1);

      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) plan_add(-1, 0);
            else plan_add($urandom_range(0, TIMEOUT - 1), $urandom_range(0, 127));
         end
         run_plan(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort during the wait of sample 2 of 5.
      for (int i = 0; i < 5; i++) plan_add(3, 9);
      rsp_d  = plan_d;
      rsp_hw = plan_hw;
      plan_d.delete();
      plan_hw.delete();
      d0 = done_cnt;
      v0 = vin_cnt;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.n_samples  = 8'd5;
      bus.src_sel    = 1'b1;
      bus.bypass_sel = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (vin_cnt < v0 + 2 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("abort_reached_sample2", 32'(vin_cnt - v0), 32'd2);
      chk("abort_partial_sum", 32'(bus.hw_sum), 32'd9);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("abort");
      repeat (2) @(negedge clk);
      rsp_d.delete();
      rsp_hw.delete();
      rst_n  = 1'b1;
      pg_exp = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      plan_add(0, 44); plan_add(2, 17);
      run_plan(2, 1'b0, 1'b0, 1'b0);

      // Full-length run at maximum weight.
      for (int i = 0; i < 255; i++) plan_add(0, 127);
      run_plan(255, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
